// File: rtl/rcvr_pkg.sv
// Shared constants and types for the receiver WSI burst sequencer.
package rcvr_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned LEN_W_DEF  = 12;
  localparam int unsigned CNT_W_DEF  = 16;

  // WSI MCmd encodings used by this master
  localparam logic [2:0] WSI_IDLE  = 3'b000;
  localparam logic [2:0] WSI_WRITE = 3'b001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } state_e;

endpackage

// File: rtl/rcvr_burst_seq_sat_counter.sv
// Width-parameterised saturating counter with synchronous clear.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // Clear wins over increment; increment stops at all-ones
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/rcvr_burst_seq.sv
// Burst sequencer: cuts the datapath sample stream into precise WSI write
// bursts and runs the start/stop/count sequence of a receiver run.
module rcvr_burst_seq
  import rcvr_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              ctl_Clk,
  input  logic              ctl_Reset,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic [LEN_W-1:0]  cfg_burst_len,
  input  logic [CNT_W-1:0]  cfg_burst_count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [2:0]        chan_MCmd,
  output logic              chan_MReqLast,
  output logic              chan_MBurstPrecise,
  output logic [LEN_W-1:0]  chan_MBurstLength,
  output logic [DATA_W-1:0] chan_MData,
  output logic              chan_MReqInfo,
  input  logic              chan_SThreadBusy,
  output logic              sts_running,
  output logic              sts_done,
  output logic [CNT_W-1:0]  sts_bursts,
  output logic [CNT_W-1:0]  sts_gaps
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic               stop_q, stop_d;
  logic [CNT_W-1:0]   bursts_q, bursts_d;
  logic               done_q, done_d;
  logic               running_q;

  logic [2:0]         mcmd_q;
  logic               last_q, precise_q, info_q;
  logic [LEN_W-1:0]   blen_q;
  logic [DATA_W-1:0]  data_q;

  logic               xfer;
  logic [LEN_W-1:0]   len_eff;
  logic               beat_valid, beat_last, end_run;
  logic [LEN_W-1:0]   beat_len;
  logic               gaps_clr, gaps_inc;

  // Handshake is purely a function of state and slave backpressure
  always_comb begin
    in_ready = ((state_q == WAIT) || (state_q == BURST)) && !chan_SThreadBusy
               && !((state_q == WAIT) && stop_q);
  end

  // Next-state, beat issue and end-of-burst decisions
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    beat_d     = beat_q;
    stop_d     = stop_q;
    bursts_d   = bursts_q;
    done_d     = 1'b0;
    beat_valid = 1'b0;
    beat_last  = 1'b0;
    beat_len   = '0;
    end_run    = 1'b0;
    gaps_clr   = 1'b0;
    gaps_inc   = 1'b0;
    xfer       = in_valid && in_ready;
    len_eff    = (cfg_burst_len == '0) ? LEN_W'(1) : cfg_burst_len;

    case (state_q)
      IDLE: begin
        if (cfg_start && !cfg_stop) begin
          state_d  = WAIT;
          bursts_d = '0;
          stop_d   = 1'b0;
          gaps_clr = 1'b1;
        end
      end
      WAIT: begin
        if (cfg_stop) begin
          state_d = IDLE;
          stop_d  = 1'b0;
          done_d  = 1'b1;
        end else if (xfer) begin
          len_d      = len_eff;
          beat_valid = 1'b1;
          beat_len   = len_eff;
          if (len_eff == LEN_W'(1)) begin
            beat_last = 1'b1;
          end else begin
            beat_d  = LEN_W'(1);
            state_d = BURST;
          end
        end
      end
      BURST: begin
        if (cfg_stop) stop_d = 1'b1;
        gaps_inc = !in_valid && !chan_SThreadBusy;
        if (xfer) begin
          beat_valid = 1'b1;
          beat_len   = len_q;
          if (beat_q == len_q - LEN_W'(1)) begin
            beat_last = 1'b1;
          end else begin
            beat_d = beat_q + LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A stop seen during the last beat itself also ends the run here
    if (beat_last) begin
      bursts_d = bursts_q + CNT_W'(1);
      if (stop_q || cfg_stop ||
          ((cfg_burst_count != '0) && (bursts_d == cfg_burst_count))) begin
        end_run = 1'b1;
        state_d = IDLE;
        stop_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d = WAIT;
      end
    end
  end

  // Control state registers
  always_ff @(posedge ctl_Clk) begin
    if (ctl_Reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      beat_q    <= '0;
      stop_q    <= 1'b0;
      bursts_q  <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      stop_q    <= stop_d;
      bursts_q  <= bursts_d;
      done_q    <= done_d;
      running_q <= (state_d != IDLE);
    end
  end

  // WSI output register: one beat per transfer, all-zero otherwise
  always_ff @(posedge ctl_Clk) begin
    if (ctl_Reset || !beat_valid) begin
      mcmd_q    <= WSI_IDLE;
      last_q    <= 1'b0;
      precise_q <= 1'b0;
      blen_q    <= '0;
      data_q    <= '0;
      info_q    <= 1'b0;
    end else begin
      mcmd_q    <= WSI_WRITE;
      last_q    <= beat_last;
      precise_q <= 1'b1;
      blen_q    <= beat_len;
      data_q    <= in_data;
      info_q    <= end_run;
    end
  end

  sat_counter #(.W(CNT_W)) u_gaps (
    .clk_i (ctl_Clk),
    .rst_i (ctl_Reset),
    .clr_i (gaps_clr),
    .inc_i (gaps_inc),
    .cnt_o (sts_gaps)
  );

  assign chan_MCmd          = mcmd_q;
  assign chan_MReqLast      = last_q;
  assign chan_MBurstPrecise = precise_q;
  assign chan_MBurstLength  = blen_q;
  assign chan_MData         = data_q;
  assign chan_MReqInfo      = info_q;
  assign sts_running        = running_q;
  assign sts_done           = done_q;
  assign sts_bursts         = bursts_q;

endmodule

// File: tb/tb_rcvr_burst_seq.sv
// Directed bench for rcvr_burst_seq with hand-computed expectations.
module tb_rcvr_burst_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop;
  logic [11:0] blen;
  logic [15:0] bcount;
  logic        valid;
  logic [31:0] data;
  logic        ready;
  logic [2:0]  mcmd;
  logic        mlast, mprecise, minfo;
  logic [11:0] mlen;
  logic [31:0] mdata;
  logic        busy;
  logic        running, done;
  logic [15:0] bursts, gaps;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rcvr_burst_seq #(.DATA_W(32), .LEN_W(12), .CNT_W(16)) dut (
    .ctl_Clk            (clk),
    .ctl_Reset          (rst),
    .cfg_start          (start),
    .cfg_stop           (stop),
    .cfg_burst_len      (blen),
    .cfg_burst_count    (bcount),
    .in_valid           (valid),
    .in_data            (data),
    .in_ready           (ready),
    .chan_MCmd          (mcmd),
    .chan_MReqLast      (mlast),
    .chan_MBurstPrecise (mprecise),
    .chan_MBurstLength  (mlen),
    .chan_MData         (mdata),
    .chan_MReqInfo      (minfo),
    .chan_SThreadBusy   (busy),
    .sts_running        (running),
    .sts_done           (done),
    .sts_bursts         (bursts),
    .sts_gaps           (gaps)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input int d, input bit last, input bit info, input int len);
    chk({tag, "_cmd"},  64'(mcmd), 64'd1);
    chk({tag, "_data"}, 64'(mdata), 64'(d));
    chk({tag, "_last"}, 64'(mlast), 64'(last));
    chk({tag, "_info"}, 64'(minfo), 64'(info));
    chk({tag, "_len"},  64'(mlen), 64'(len));
    chk({tag, "_prec"}, 64'(mprecise), 64'd1);
  endtask

  task automatic idle_beat(input string tag);
    chk({tag, "_cmd"},  64'(mcmd), 64'd0);
    chk({tag, "_data"}, 64'(mdata), 64'd0);
    chk({tag, "_len"},  64'(mlen), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; start = 0; stop = 0; blen = '0; bcount = '0;
    valid = 0; data = '0; busy = 0;
    step(); step();
    idle_beat("rst");
    chk("rst_last", 64'(mlast), 0);
    chk("rst_prec", 64'(mprecise), 0);
    chk("rst_info", 64'(minfo), 0);
    chk("rst_rdy", 64'(ready), 0);
    chk("rst_run", 64'(running), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_bursts", 64'(bursts), 0);
    chk("rst_gaps", 64'(gaps), 0);
    rst = 0;
    step();
    chk("idle_rdy", 64'(ready), 0);

    // len=4, count=2: two bursts, info and done on word 8
    blen = 12'd4; bcount = 16'd2; start = 1;
    step(); start = 0;
    chk("t1_run", 64'(running), 1);
    chk("t1_rdy", 64'(ready), 1);
    valid = 1;
    for (int i = 1; i <= 8; i++) begin
      data = 32'(i);
      step();
      beat($sformatf("t1_b%0d", i), i, (i % 4) == 0, i == 8, 4);
      chk($sformatf("t1_done%0d", i), 64'(done), 64'(i == 8));
      chk($sformatf("t1_bursts%0d", i), 64'(bursts), 64'(i / 4));
    end
    chk("t1_run_end", 64'(running), 0);
    chk("t1_rdy_end", 64'(ready), 0);
    step();
    idle_beat("t1_after");
    chk("t1_done_after", 64'(done), 0);
    chk("t1_bursts_after", 64'(bursts), 2);
    valid = 0;

    // len=0 behaves as single-beat bursts
    blen = 12'd0; bcount = 16'd3; start = 1;
    step(); start = 0;
    chk("t2_bursts_clr", 64'(bursts), 0);
    valid = 1;
    for (int i = 1; i <= 3; i++) begin
      data = 32'(16 + i);
      step();
      beat($sformatf("t2_b%0d", i), 16 + i, 1'b1, i == 3, 1);
    end
    valid = 0;
    step();
    chk("t2_run", 64'(running), 0);
    chk("t2_bursts", 64'(bursts), 3);

    // len=8 with 3 busy cycles after beat 2
    blen = 12'd8; bcount = 16'd1; start = 1;
    step(); start = 0;
    valid = 1;
    for (int i = 1; i <= 2; i++) begin
      data = 32'(32 + i);
      step();
      beat($sformatf("t3_b%0d", i), 32 + i, 1'b0, 1'b0, 8);
    end
    busy = 1; data = 32'd35;
    #1;
    chk("t3_rdy_busy", 64'(ready), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      idle_beat($sformatf("t3_busy%0d", k));
      chk($sformatf("t3_rdy%0d", k), 64'(ready), 0);
    end
    busy = 0;
    for (int i = 3; i <= 8; i++) begin
      data = 32'(32 + i);
      step();
      beat($sformatf("t3_b%0d", i), 32 + i, i == 8, i == 8, 8);
    end
    chk("t3_gaps", 64'(gaps), 0);
    chk("t3_done", 64'(done), 1);
    valid = 0;
    step();

    // len=8 with 5 starve cycles mid-burst
    start = 1;
    step(); start = 0;
    valid = 1;
    for (int i = 1; i <= 3; i++) begin
      data = 32'(48 + i);
      step();
      beat($sformatf("t4_b%0d", i), 48 + i, 1'b0, 1'b0, 8);
    end
    valid = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      idle_beat($sformatf("t4_gap%0d", k));
    end
    chk("t4_gaps_mid", 64'(gaps), 5);
    valid = 1;
    for (int i = 4; i <= 8; i++) begin
      data = 32'(48 + i);
      step();
      beat($sformatf("t4_b%0d", i), 48 + i, i == 8, i == 8, 8);
    end
    chk("t4_gaps_end", 64'(gaps), 5);
    chk("t4_bursts", 64'(bursts), 1);
    valid = 0;
    step();

    // stop at beat 3 of len=6, unlimited count
    blen = 12'd6; bcount = 16'd0; start = 1;
    step(); start = 0;
    valid = 1;
    for (int i = 1; i <= 6; i++) begin
      data = 32'(64 + i);
      stop = (i == 3);
      step();
      stop = 0;
      beat($sformatf("t5_b%0d", i), 64 + i, i == 6, i == 6, 6);
      chk($sformatf("t5_done%0d", i), 64'(done), 64'(i == 6));
    end
    chk("t5_run", 64'(running), 0);
    valid = 0;
    step();
    chk("t5_done_after", 64'(done), 0);
    start = 1; stop = 1;
    step(); start = 0; stop = 0;
    chk("t5_startstop_run", 64'(running), 0);
    step();
    chk("t5_startstop_run2", 64'(running), 0);

    // reset in the middle of the second burst
    blen = 12'd4; bcount = 16'd0; start = 1;
    step(); start = 0;
    valid = 1;
    for (int i = 1; i <= 6; i++) begin
      data = 32'(80 + i);
      step();
      beat($sformatf("t6_b%0d", i), 80 + i, i == 4, 1'b0, 4);
    end
    valid = 0;
    step();
    chk("t6_gaps_pre", 64'(gaps), 1);
    chk("t6_bursts_pre", 64'(bursts), 1);
    valid = 1; data = 32'd87; rst = 1;
    step();
    idle_beat("t6_rst");
    chk("t6_rst_run", 64'(running), 0);
    chk("t6_rst_bursts", 64'(bursts), 0);
    chk("t6_rst_gaps", 64'(gaps), 0);
    chk("t6_rst_done", 64'(done), 0);
    chk("t6_rst_rdy", 64'(ready), 0);
    rst = 0; valid = 0;
    step();
    chk("t6_post_done", 64'(done), 0);
    idle_beat("t6_post");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
